// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_pkg
//  Description : Shared constants for the JPEG quantize/zigzag stage:
//                coefficient width, zigzag scan LUT, Annex K quality-50
//                luma/chroma tables, component enum and the fixed-point
//                reciprocal used by the quantizer.
//  Revision    : 1.0  initial release
// ============================================================================
package jpeg_pkg;

  localparam int CW = 11;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  typedef enum logic {
    BUF_EMPTY  = 1'b0,
    BUF_STREAM = 1'b1
  } buf_state_e;

  // Zigzag position k -> natural (row-major) index.
  localparam logic [5:0] c_zigzag [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  // Luma quantization table, natural order.
  localparam logic [7:0] c_luma_q [64] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  // Chroma quantization table, natural order.
  localparam logic [7:0] c_chroma_q [64] = '{
    17,  18,  24,  47,  99,  99,  99,  99,
    18,  21,  26,  66,  99,  99,  99,  99,
    24,  26,  56,  99,  99,  99,  99,  99,
    47,  66,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99
  };

  // Zigzag position -> natural index.
  function automatic logic [5:0] zz(input logic [5:0] k);
    return c_zigzag[k];
  endfunction

  // R = floor((65536 + Q/2) / Q); Q=0 behaves as Q=1, so R fits 17 bits.
  function automatic logic [16:0] recip(input logic [7:0] q);
    logic [17:0] d;
    logic [17:0] num;
    d   = (q == 8'd0) ? 18'd1 : {10'd0, q};
    num = 18'd65536 + {1'b0, d[17:1]};
    return 17'(num / d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_quant_core.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_quant_core
//  Description : Combinational quantizer. |c| is scaled by the reciprocal of
//                Q in 16-bit fixed point with +0.5 rounding, then the sign is
//                restored (round half away from zero).
//  Revision    : 1.0  initial release
// ============================================================================
module jpeg_quant_core
  import jpeg_pkg::*;
#(
  parameter int CW = jpeg_pkg::CW
) (
  input  logic signed [CW-1:0] coef,
  input  logic        [7:0]    q,
  output logic signed [CW-1:0] qcoef
);

  localparam int PW = CW + 17;

  logic [CW-1:0] w_mag;
  logic [16:0]   w_recip;
  logic [PW-1:0] w_sum;
  logic [CW-1:0] w_m;

  // Magnitude times reciprocal plus half, shifted down, then sign restored.
  always_comb begin
    // -1024 negates to the bit pattern 1024, which is the correct magnitude.
    w_mag   = coef[CW-1] ? CW'(-coef) : CW'(coef);
    w_recip = recip(q);
    w_sum   = PW'(w_mag) * PW'(w_recip) + PW'(32'd32768);
    w_m     = CW'(w_sum >> 16);
    qcoef   = coef[CW-1] ? -w_m : w_m;
  end

endmodule
`default_nettype wire

// File: rtl/jpeg_quant_zigzag.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_quant_zigzag
//  Description : Captures 8x8 DCT blocks into a two-entry ping-pong buffer,
//                quantizes each coefficient with the luma or chroma table and
//                streams the results one per cycle in zigzag order.
//                Optional macro QTABLE_PROG_EN turns the quantization tables
//                into writable registers (qt_* ports).
//  Revision    : 1.0  initial release
// ============================================================================
module jpeg_quant_zigzag
  import jpeg_pkg::*;
#(
  parameter int CW   = jpeg_pkg::CW,
  parameter int NBUF = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [64*CW-1:0]     coef_in,
  input  logic [1:0]           comp_in,
`ifdef QTABLE_PROG_EN
  input  logic                 qt_we,
  input  logic                 qt_sel,
  input  logic [5:0]           qt_addr,
  input  logic [7:0]           qt_data,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [CW-1:0] out_coef,
  output logic [5:0]           out_idx,
  output logic [1:0]           out_comp,
  output logic                 out_last,
  output logic                 ovf
);

  logic [CW-1:0]        r_buf        [NBUF][64];
  comp_e                r_bcomp      [NBUF];
  buf_state_e           r_bstate     [NBUF];
  buf_state_e           w_bstate_nxt [NBUF];
  logic                 r_wptr;
  logic                 r_rptr;
  logic [5:0]           r_cnt;

  logic                 w_accept;
  logic                 w_load;
  logic                 w_wrap;
  comp_e                w_comp_norm;
  logic [5:0]           w_nat;
  logic signed [CW-1:0] w_coef;
  logic signed [CW-1:0] w_qcoef;
  logic [7:0]           w_q;
  logic                 w_tsel;

  // Handshake and load qualifiers; in_ready depends only on registered state.
  assign in_ready    = (r_bstate[r_wptr] == BUF_EMPTY);
  assign w_accept    = in_valid && in_ready;
  assign w_load      = (!out_valid || out_ready) && (r_bstate[r_rptr] == BUF_STREAM);
  assign w_wrap      = w_load && (r_cnt == 6'd63);
  assign w_comp_norm = (comp_in == 2'd3) ? COMP_CR : comp_e'(comp_in);

  // Block payload: unpacked into per-coefficient slots; state flags gate use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int n = 0; n < 64; n++) begin
        r_buf[r_wptr][n] <= coef_in[(64*CW-1) - CW*n -: CW];
      end
      r_bcomp[r_wptr] <= w_comp_norm;
    end
  end

  // Per-buffer drain state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBUF; b++) begin
        r_bstate[b] <= BUF_EMPTY;
      end
    end else begin
      r_bstate <= w_bstate_nxt;
    end
  end

  // Next state: loading idx 63 frees the read buffer, a capture fills the write buffer.
  always_comb begin
    w_bstate_nxt = r_bstate;
    if (w_wrap) begin
      w_bstate_nxt[r_rptr] = BUF_EMPTY;
    end
    if (w_accept) begin
      w_bstate_nxt[r_wptr] = BUF_STREAM;
    end
  end

  // Coefficient selection for the current zigzag position.
  assign w_nat  = zz(r_cnt);
  assign w_coef = r_buf[r_rptr][w_nat];
  assign w_tsel = (r_bcomp[r_rptr] != COMP_Y);

`ifdef QTABLE_PROG_EN
  logic [7:0] r_qt [2][64];

  // Writable tables, reset to Annex K; a write is visible to the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 64; n++) begin
        r_qt[0][n] <= c_luma_q[n];
        r_qt[1][n] <= c_chroma_q[n];
      end
    end else if (qt_we) begin
      r_qt[qt_sel][qt_addr] <= qt_data;
    end
  end

  assign w_q = r_qt[w_tsel][w_nat];
`else
  assign w_q = w_tsel ? c_chroma_q[w_nat] : c_luma_q[w_nat];
`endif

  jpeg_quant_core #(
    .CW    (CW)
  ) u_quant (
    .coef  (w_coef),
    .q     (w_q),
    .qcoef (w_qcoef)
  );

  // Pointers, zigzag counter, output register and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_cnt     <= 6'd0;
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_idx   <= 6'd0;
      out_comp  <= 2'd0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wptr <= ~r_wptr;
      end
      if (in_valid && !in_ready) begin
        ovf <= 1'b1;
      end
      if (w_load) begin
        out_valid <= 1'b1;
        out_coef  <= w_qcoef;
        out_idx   <= r_cnt;
        out_comp  <= r_bcomp[r_rptr];
        out_last  <= (r_cnt == 6'd63);
        r_cnt     <= r_cnt + 6'd1;
        if (w_wrap) begin
          r_rptr <= ~r_rptr;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
